// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALUOp codes,
// FSM states, datapath mux select codes and the bundled control word.
package mips_ctrl_pkg;

  localparam int ALUOP_WIDTH = 3;
  typedef logic [ALUOP_WIDTH-1:0] aluop_t;

  localparam aluop_t ALU_R    = 3'b111;
  localparam aluop_t ALU_ANDI = 3'b110;
  localparam aluop_t ALU_ORI  = 3'b101;
  localparam aluop_t ALU_ADD  = 3'b100;
  localparam aluop_t ALU_LUI  = 3'b011;
  localparam aluop_t ALU_SUB  = 3'b001;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [1:0] M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
  localparam logic [1:0] RDST_RT = 2'b00, RDST_RD = 2'b01, RDST_RA = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_A = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_source;
    aluop_t     alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic aluop_t imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALU_ANDI;
      OP_ORI:  imm_alu_op = ALU_ORI;
      OP_LUI:  imm_alu_op = ALU_LUI;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational map of (state, opcode, jr, mem_ready, run) to the control word
// and next state; while run is low every enable is suppressed and the state holds.
module multicycle_control_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic       jr_i,
  input  logic       mem_ready_i,
  input  logic       run_i,
  output ctrl_t      ctrl_o,
  output state_t     next_state_o
);

  ctrl_t  c;
  state_t nxt;

  always_comb begin
    c   = '0;
    nxt = state_i;
    case (state_i)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_4;
        c.alu_op    = ALU_ADD;
        if (mem_ready_i) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          nxt        = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALU_ADD;
        case (opcode_i)
          OP_LW, OP_SW:                      nxt = S_MEM_ADDR;
          OP_R:                              nxt = S_R_EXEC;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  nxt = S_I_EXEC;
          OP_BEQ, OP_BNE:                    nxt = S_BRANCH;
          OP_J, OP_JAL:                      nxt = S_JUMP;
          default: begin
            c.illegal_op = 1'b1;
            nxt          = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        nxt         = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        if (mem_ready_i) nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_MDR;
        c.reg_dst    = RDST_RT;
        nxt          = S_FETCH;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        if (mem_ready_i) nxt = S_FETCH;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_R;
        if (jr_i) begin
          c.pc_write  = 1'b1;
          c.pc_source = PCSRC_A;
          nxt         = S_FETCH;
        end else begin
          nxt = S_R_WB;
        end
      end
      S_R_WB: begin
        c.alu_op     = ALU_R;
        c.reg_write  = 1'b1;
        c.reg_dst    = RDST_RD;
        c.mem_to_reg = M2R_ALUOUT;
        nxt          = S_FETCH;
      end
      S_I_EXEC, S_I_WB: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = imm_alu_op(opcode_i);
        c.zero_ext  = (opcode_i == OP_ANDI) || (opcode_i == OP_ORI);
        if (state_i == S_I_WB) begin
          c.reg_write = 1'b1;
          c.reg_dst   = RDST_RT;
          nxt         = S_FETCH;
        end else begin
          nxt = S_I_WB;
        end
      end
      S_BRANCH: begin
        c.alu_src_a        = 1'b1;
        c.alu_src_b        = SRCB_B;
        c.alu_op           = ALU_SUB;
        c.pc_source        = PCSRC_ALUOUT;
        c.pc_write_cond    = (opcode_i == OP_BEQ);
        c.pc_write_cond_ne = (opcode_i == OP_BNE);
        nxt                = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
        if (opcode_i == OP_JAL) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = RDST_RA;
          c.mem_to_reg = M2R_PC;
        end
        nxt = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase

    if (!run_i) begin
      c.pc_write         = 1'b0;
      c.pc_write_cond    = 1'b0;
      c.pc_write_cond_ne = 1'b0;
      c.ir_write         = 1'b0;
      c.reg_write        = 1'b0;
      c.mem_read         = 1'b0;
      c.mem_write        = 1'b0;
      nxt                = state_i;
    end
  end

  assign ctrl_o       = c;
  assign next_state_o = nxt;

endmodule

// File: rtl/multicycle_control.sv
// Main multicycle MIPS control FSM: state register, run flop and decode wrapper.
// Optional retired-instruction counter under MULTICYCLE_CTRL_RETIRE_COUNT_EN.
module multicycle_control
  import mips_ctrl_pkg::*;
`ifdef MULTICYCLE_CTRL_RETIRE_COUNT_EN
#(
  parameter int CNT_WIDTH = 32
)
`endif
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   jr,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   pc_write_cond_ne,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_write,
  output logic [1:0]             mem_to_reg,
  output logic [1:0]             reg_dst,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic                   zero_ext,
  output logic [1:0]             pc_source,
  output logic [ALUOP_WIDTH-1:0] alu_op,
`ifdef MULTICYCLE_CTRL_RETIRE_COUNT_EN
  output logic [CNT_WIDTH-1:0]   instr_count,
`endif
  output logic                   illegal_op
);

  state_t state_q, state_d;
  logic   run_q;
  ctrl_t  ctrl;

  multicycle_control_decode u_decode (
    .state_i      (state_q),
    .opcode_i     (opcode),
    .jr_i         (jr),
    .mem_ready_i  (mem_ready),
    .run_i        (run_q),
    .ctrl_o       (ctrl),
    .next_state_o (state_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

`ifdef MULTICYCLE_CTRL_RETIRE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 retire;

  // DECODE->FETCH (illegal opcode) is deliberately not a retiring transition.
  assign retire = run_q && (state_d == S_FETCH) &&
                  (state_q inside {S_MEM_WB, S_MEM_WRITE, S_R_EXEC, S_R_WB,
                                   S_I_WB, S_BRANCH, S_JUMP});
  assign cnt_d  = retire ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

  assign pc_write         = ctrl.pc_write;
  assign pc_write_cond    = ctrl.pc_write_cond;
  assign pc_write_cond_ne = ctrl.pc_write_cond_ne;
  assign iord             = ctrl.iord;
  assign mem_read         = ctrl.mem_read;
  assign mem_write        = ctrl.mem_write;
  assign ir_write         = ctrl.ir_write;
  assign reg_write        = ctrl.reg_write;
  assign mem_to_reg       = ctrl.mem_to_reg;
  assign reg_dst          = ctrl.reg_dst;
  assign alu_src_a        = ctrl.alu_src_a;
  assign alu_src_b        = ctrl.alu_src_b;
  assign zero_ext         = ctrl.zero_ext;
  assign pc_source        = ctrl.pc_source;
  assign alu_op           = ctrl.alu_op;
  assign illegal_op       = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control; instr_count is checked
// when MULTICYCLE_CTRL_RETIRE_COUNT_EN is defined.
module tb_multicycle_control;

  localparam logic [5:0] R = 6'b000000, J = 6'b000010, JAL = 6'b000011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, LUI = 6'b001111;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, ILL = 6'b111111;

  // en = {pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write, ir_write, reg_write}
  typedef struct packed {
    logic [7:0] en;
    logic [1:0] m2r;
    logic [1:0] rdst;
    logic       sa;
    logic [1:0] sb;
    logic       zx;
    logic [1:0] ps;
    logic [2:0] aop;
    logic       ill;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       jr;
    logic       rdy;
    int         cnt;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode;
  logic jr, mem_ready;
  logic pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] mem_to_reg, reg_dst, alu_src_b, pc_source;
  logic alu_src_a, zero_ext, illegal_op;
  logic [2:0] alu_op;
`ifdef MULTICYCLE_CTRL_RETIRE_COUNT_EN
  logic [31:0] instr_count;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk              (clk),
    .reset            (reset),
    .opcode           (opcode),
    .jr               (jr),
    .mem_ready        (mem_ready),
    .pc_write         (pc_write),
    .pc_write_cond    (pc_write_cond),
    .pc_write_cond_ne (pc_write_cond_ne),
    .iord             (iord),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .ir_write         (ir_write),
    .reg_write        (reg_write),
    .mem_to_reg       (mem_to_reg),
    .reg_dst          (reg_dst),
    .alu_src_a        (alu_src_a),
    .alu_src_b        (alu_src_b),
    .zero_ext         (zero_ext),
    .pc_source        (pc_source),
    .alu_op           (alu_op),
`ifdef MULTICYCLE_CTRL_RETIRE_COUNT_EN
    .instr_count      (instr_count),
`endif
    .illegal_op       (illegal_op)
  );

  task automatic chk(input string nm, input outs_t exp, input int cnt);
    outs_t act;
    act = '{en: {pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write, ir_write, reg_write},
            m2r: mem_to_reg, rdst: reg_dst, sa: alu_src_a, sb: alu_src_b, zx: zero_ext,
            ps: pc_source, aop: alu_op, ill: illegal_op};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: outputs actual=%06h required=%06h (en act=%08b req=%08b)",
                  nm, act, exp, act.en, exp.en);
`ifdef MULTICYCLE_CTRL_RETIRE_COUNT_EN
    n_checks++;
    if (instr_count === 32'(cnt)) n_pass++;
    else $display("FAIL %s: instr_count actual=%0d required=%0d", nm, instr_count, cnt);
`else
    if (cnt < 0) $display("note: negative count in %s", nm);
`endif
  endtask

  task automatic v(input logic [5:0] op, input logic j, input logic rdy, input int cnt,
                   input logic [7:0] en, input logic [1:0] m2r, input logic [1:0] rdst,
                   input logic sa, input logic [1:0] sb, input logic zx, input logic [1:0] ps,
                   input logic [2:0] aop, input logic ill);
    vec_t e;
    e.op = op; e.jr = j; e.rdy = rdy; e.cnt = cnt;
    e.exp = '{en: en, m2r: m2r, rdst: rdst, sa: sa, sb: sb, zx: zx, ps: ps, aop: aop, ill: ill};
    tbl.push_back(e);
  endtask

  task automatic f(input logic [5:0] op, input int cnt);
    v(op, 1'b0, 1'b1, cnt, 8'b1000_1010, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00, 3'b100, 1'b0);
  endtask

  task automatic d(input logic [5:0] op, input int cnt);
    v(op, 1'b0, 1'b1, cnt, 8'b0000_0000, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 2'b00, 3'b100, 1'b0);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      opcode = tbl[i].op; jr = tbl[i].jr; mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("%s[%0d]", tag, i), tbl[i].exp, tbl[i].cnt);
      @(posedge clk); #1;
    end
    tbl.delete();
  endtask

  outs_t reset_exp;

  initial begin
    reset_exp = '{en: 8'h00, m2r: 2'b00, rdst: 2'b00, sa: 1'b0, sb: 2'b01, zx: 1'b0,
                  ps: 2'b00, aop: 3'b100, ill: 1'b0};
    reset = 1'b0; opcode = R; jr = 1'b0; mem_ready = 1'b1;
    #3 chk("in_reset", reset_exp, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("dead_cycle", reset_exp, 0);
    @(posedge clk); #1;

    // R-type, jr=0
    f(R,0); d(R,0);
    v(R,0,1,0, 8'b0000_0000,2'b00,2'b00,1,2'b00,0,2'b00,3'b111,0);
    v(R,0,1,0, 8'b0000_0001,2'b00,2'b01,0,2'b00,0,2'b00,3'b111,0);
    // LW with three wait cycles in MEM_READ
    f(LW,1); d(LW,1);
    v(LW,0,1,1, 8'b0000_0000,2'b00,2'b00,1,2'b10,0,2'b00,3'b100,0);
    for (int k = 0; k < 3; k++) v(LW,0,0,1, 8'b0001_1000,2'b00,2'b00,0,2'b00,0,2'b00,3'b000,0);
    v(LW,0,1,1, 8'b0001_1000,2'b00,2'b00,0,2'b00,0,2'b00,3'b000,0);
    v(LW,0,1,1, 8'b0000_0001,2'b01,2'b00,0,2'b00,0,2'b00,3'b000,0);
    // BNE
    f(BNE,2); d(BNE,2);
    v(BNE,0,1,2, 8'b0010_0000,2'b00,2'b00,1,2'b00,0,2'b01,3'b001,0);
    // JR
    f(R,3); d(R,3);
    v(R,1,1,3, 8'b1000_0000,2'b00,2'b00,1,2'b00,0,2'b11,3'b111,0);
    // illegal opcode, then ADDI
    f(ILL,4);
    v(ILL,0,1,4, 8'b0000_0000,2'b00,2'b00,0,2'b11,0,2'b00,3'b100,1);
    f(ADDI,4); d(ADDI,4);
    v(ADDI,0,1,4, 8'b0000_0000,2'b00,2'b00,1,2'b10,0,2'b00,3'b100,0);
    v(ADDI,0,1,4, 8'b0000_0001,2'b00,2'b00,1,2'b10,0,2'b00,3'b100,0);
    // SW with one wait cycle
    f(SW,5); d(SW,5);
    v(SW,0,1,5, 8'b0000_0000,2'b00,2'b00,1,2'b10,0,2'b00,3'b100,0);
    v(SW,0,0,5, 8'b0001_0100,2'b00,2'b00,0,2'b00,0,2'b00,3'b000,0);
    v(SW,0,1,5, 8'b0001_0100,2'b00,2'b00,0,2'b00,0,2'b00,3'b000,0);
    // BEQ, J, JAL
    f(BEQ,6); d(BEQ,6);
    v(BEQ,0,1,6, 8'b0100_0000,2'b00,2'b00,1,2'b00,0,2'b01,3'b001,0);
    f(J,7); d(J,7);
    v(J,0,1,7, 8'b1000_0000,2'b00,2'b00,0,2'b00,0,2'b10,3'b000,0);
    f(JAL,8); d(JAL,8);
    v(JAL,0,1,8, 8'b1000_0001,2'b10,2'b10,0,2'b00,0,2'b10,3'b000,0);
    // ANDI, ORI (after a stalled fetch), LUI
    f(ANDI,9); d(ANDI,9);
    v(ANDI,0,1,9, 8'b0000_0000,2'b00,2'b00,1,2'b10,1,2'b00,3'b110,0);
    v(ANDI,0,1,9, 8'b0000_0001,2'b00,2'b00,1,2'b10,1,2'b00,3'b110,0);
    v(ORI,0,0,10, 8'b0000_1000,2'b00,2'b00,0,2'b01,0,2'b00,3'b100,0);
    f(ORI,10); d(ORI,10);
    v(ORI,0,1,10, 8'b0000_0000,2'b00,2'b00,1,2'b10,1,2'b00,3'b101,0);
    v(ORI,0,1,10, 8'b0000_0001,2'b00,2'b00,1,2'b10,1,2'b00,3'b101,0);
    f(LUI,11); d(LUI,11);
    v(LUI,0,1,11, 8'b0000_0000,2'b00,2'b00,1,2'b10,0,2'b00,3'b011,0);
    v(LUI,0,1,11, 8'b0000_0001,2'b00,2'b00,1,2'b10,0,2'b00,3'b011,0);
    v(R,0,0,12, 8'b0000_1000,2'b00,2'b00,0,2'b01,0,2'b00,3'b100,0);
    run_table("main");

    // Reset pulled low while an LW waits in MEM_READ
    f(LW,12); d(LW,12);
    v(LW,0,1,12, 8'b0000_0000,2'b00,2'b00,1,2'b10,0,2'b00,3'b100,0);
    v(LW,0,0,12, 8'b0001_1000,2'b00,2'b00,0,2'b00,0,2'b00,3'b000,0);
    run_table("lw_abort");
    opcode = LW; mem_ready = 1'b1;
    #2 reset = 1'b0;
    #1 chk("abort_in_reset", reset_exp, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("abort_dead_cycle", reset_exp, 0);
    @(posedge clk); #1;
    chk("abort_first_fetch", '{en: 8'b1000_1010, m2r: 2'b00, rdst: 2'b00, sa: 1'b0, sb: 2'b01,
                               zx: 1'b0, ps: 2'b00, aop: 3'b100, ill: 1'b0}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
